// File: rtl/ysyx_22050518_div_if.sv
// Request/response bundle between the execute stage and the divider.
// Master is the initiator, slave is the divider.
interface ysyx_22050518_div_if #(
    parameter int XLEN = 64
);
    logic            div_valid;
    logic            flush;
    logic            divw;
    logic            div_signed;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_ready;
    logic            out_valid;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    modport master (
        output div_valid, flush, divw, div_signed, dividend, divisor,
        input  div_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  div_valid, flush, divw, div_signed, dividend, divisor,
        output div_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/ysyx_22050518_div.sv
// Radix-2 restoring divider for RV64M div/rem (incl. W forms).
// YSYX_22050518_DIV_FAST_EN: finish div-by-zero/overflow in one cycle.
module ysyx_22050518_div #(
    parameter int XLEN = 64
) (
    input logic                clk,
    input logic                rst_n,
    ysyx_22050518_div_if.slave io
);
    localparam int HX = XLEN / 2;
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_F = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [HX-1:0]   MIN_H = {1'b1, {(HX-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, raw_q, raw_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d;
    logic [XLEN:0]   r_q, r_d;
    logic            w_q, w_d, sq_q, sq_d, sr_q, sr_d;
    logic            zero_q, zero_d, ovf_q, ovf_d;
    logic            rdy_q, rdy_d, ov_q, ov_d;

    logic            accept, a_neg, b_neg, is_zero, is_ovf, qbit;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_nx;
    logic [XLEN:0]   r_sh, r_sub, r_nx;
    logic [2*XLEN-1:0] fin_calc;
`ifdef YSYX_22050518_DIV_FAST_EN
    logic [2*XLEN-1:0] fin_acc;
`endif

    // Sign fixup, RISC-V special-case override, then W-form sign extension.
    function automatic logic [2*XLEN-1:0] fixup(
        input logic w, sq, sr, zero, ovf,
        input logic [XLEN-1:0] raw, qm, rm
    );
        logic [XLEN-1:0] q, r;
        q = sq ? -qm : qm;
        r = sr ? -rm : rm;
        if (zero) begin
            q = '1;
            r = raw;
        end else if (ovf) begin
            q = raw;
            r = '0;
        end
        if (w) begin
            q = {{HX{q[HX-1]}}, q[HX-1:0]};
            r = {{HX{r[HX-1]}}, r[HX-1:0]};
        end
        return {q, r};
    endfunction

    always_comb begin
        a_ext = io.divw ? {{HX{io.div_signed & io.dividend[HX-1]}},
                           io.dividend[HX-1:0]} : io.dividend;
        b_ext = io.divw ? {{HX{io.div_signed & io.divisor[HX-1]}},
                           io.divisor[HX-1:0]} : io.divisor;
        a_neg = io.div_signed & a_ext[XLEN-1];
        b_neg = io.div_signed & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
        is_zero = (b_ext == '0);
        is_ovf = io.div_signed & (b_ext == '1) &
                 (io.divw ? (a_ext[HX-1:0] == MIN_H) : (a_ext == MIN_F));
        r_sh  = {r_q[XLEN-1:0], a_q[XLEN-1]};
        r_sub = r_sh - {1'b0, b_q};
        qbit  = ~r_sub[XLEN];
        r_nx  = qbit ? r_sub : r_sh;
        a_nx  = {a_q[XLEN-2:0], qbit};
        fin_calc = fixup(w_q, sq_q, sr_q, zero_q, ovf_q, raw_q,
                         a_nx, r_nx[XLEN-1:0]);
`ifdef YSYX_22050518_DIV_FAST_EN
        fin_acc = fixup(io.divw, 1'b0, 1'b0, is_zero, is_ovf, a_ext,
                        '0, '0);
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        raw_d   = raw_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        w_d     = w_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        rdy_d   = rdy_q;
        ov_d    = 1'b0;
        accept  = io.div_valid & rdy_q & ~io.flush;
        if (io.flush) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                    if (accept) begin
                        state_d = CALC;
                        rdy_d   = 1'b0;
                        // W-form magnitude sits in the top half so MSB-first works.
                        a_d    = io.divw ? {a_mag[HX-1:0], {HX{1'b0}}} : a_mag;
                        b_d    = b_mag;
                        r_d    = '0;
                        raw_d  = a_ext;
                        cnt_d  = io.divw ? CW'(HX - 1) : CW'(XLEN - 1);
                        w_d    = io.divw;
                        sq_d   = a_neg ^ b_neg;
                        sr_d   = a_neg;
                        zero_d = is_zero;
                        ovf_d  = is_ovf;
`ifdef YSYX_22050518_DIV_FAST_EN
                        if (is_zero | is_ovf) begin
                            state_d        = DONE;
                            rdy_d          = 1'b1;
                            ov_d           = 1'b1;
                            {quo_d, rem_d} = fin_acc;
                        end
`endif
                    end
                end
                CALC: begin
                    a_d   = a_nx;
                    r_d   = r_nx;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        cnt_d          = '0;
                        state_d        = DONE;
                        rdy_d          = 1'b1;
                        ov_d           = 1'b1;
                        {quo_d, rem_d} = fin_calc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            raw_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            w_q     <= 1'b0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b1;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            raw_q   <= raw_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            w_q     <= w_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
            ov_q    <= ov_d;
        end
    end

    assign io.div_ready = rdy_q;
    assign io.out_valid = ov_q;
    assign io.quotient  = quo_q;
    assign io.remainder = rem_q;
endmodule

// File: tb/tb_ysyx_22050518_div.sv
// Self-checking bench for ysyx_22050518_div: directed, random, flush, reset.
// Reference results come from plain SV division plus RISC-V special cases.
module tb_ysyx_22050518_div;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    ysyx_22050518_div_if #(.XLEN(64)) io ();

    ysyx_22050518_div #(.XLEN(64)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void ref_div(
        input bit w, input bit s, input logic [63:0] a, input logic [63:0] b,
        output logic [63:0] q, output logic [63:0] r
    );
        logic [31:0] a32, b32, q32, r32;
        int          sa32, sb32;
        longint      sa, sb;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            sa32 = a32;
            sb32 = b32;
            if (b32 == 32'd0) begin
                q32 = '1;
                r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32;
                r32 = '0;
            end else if (s) begin
                q32 = sa32 / sb32;
                r32 = sa32 % sb32;
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            sa = a;
            sb = b;
            if (b == 64'd0) begin
                q = '1;
                r = a;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a;
                r = '0;
            end else if (s) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    function automatic int ref_lat(
        input bit w, input bit s, input logic [63:0] a, input logic [63:0] b
    );
        bit special;
        if (w)
            special = (b[31:0] == 32'd0) ||
                      (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else
            special = (b == 64'd0) ||
                      (s && a == 64'h8000_0000_0000_0000 && b == '1);
`ifdef YSYX_22050518_DIV_FAST_EN
        if (special) return 1;
`else
        if (special) return w ? 33 : 65;
`endif
        return w ? 33 : 65;
    endfunction

    // Issue one request now (mid-cycle), then wait for out_valid.
    task automatic run_op(
        input bit w, input bit s, input logic [63:0] a, input logic [63:0] b,
        output logic [63:0] q, output logic [63:0] r,
        output int lat, output bit rdy_ok
    );
        io.divw       = w;
        io.div_signed = s;
        io.dividend   = a;
        io.divisor    = b;
        io.div_valid  = 1'b1;
        @(posedge clk);
        #1;
        io.div_valid  = 1'b0;
        io.dividend   = {$urandom, $urandom};
        io.divisor    = {$urandom, $urandom};
        io.divw       = 1'($urandom);
        io.div_signed = 1'($urandom);
        rdy_ok = 1'b1;
        lat = 1;
        while (io.out_valid !== 1'b1 && lat < 200) begin
            if (io.div_ready !== 1'b0) rdy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        q = io.quotient;
        r = io.remainder;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        io.div_valid  = 1'b0;
        io.flush      = 1'b0;
        io.divw       = 1'b0;
        io.div_signed = 1'b0;
        io.dividend   = '0;
        io.divisor    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (io.div_ready !== 1'b1 || io.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hs got rdy=%b ov=%b exp rdy=1 ov=0",
                     io.div_ready, io.out_valid);
        end
        n_cmp++;
        if (io.quotient !== 64'd0 || io.remainder !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_res got q=%h r=%h exp 0/0",
                     io.quotient, io.remainder);
        end
    endtask

    task automatic test_directed;
        logic [63:0] q, r;
        int lat;
        bit rok;
        run_op(1'b0, 1'b0, 64'd100, 64'd7, q, r, lat, rok);
        n_cmp++;
        if ({q, r} !== {64'd14, 64'd2}) begin
            n_bad++;
            $display("FAIL udiv100_7 got q=%h r=%h exp 14/2", q, r);
        end
        n_cmp++;
        if (lat !== 65 || !rok) begin
            n_bad++;
            $display("FAIL udiv100_7_lat got lat=%0d rdy_ok=%0d exp 65/1", lat, rok);
        end
        run_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, q, r, lat, rok);
        n_cmp++;
        if ({q, r} !== {64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF}) begin
            n_bad++;
            $display("FAIL sdiv_m7_2 got q=%h r=%h exp fffffffffffffffd/ffffffffffffffff", q, r);
        end
        run_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               q, r, lat, rok);
        n_cmp++;
        if ({q, r} !== {64'hFFFF_FFFF_8000_0000, 64'd0}) begin
            n_bad++;
            $display("FAIL divw_ovf got q=%h r=%h exp ffffffff80000000/0", q, r);
        end
        n_cmp++;
`ifdef YSYX_22050518_DIV_FAST_EN
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL divw_ovf_lat got %0d exp 1", lat);
        end
`else
        if (lat !== 33 || !rok) begin
            n_bad++;
            $display("FAIL divw_ovf_lat got %0d rdy_ok=%0d exp 33/1", lat, rok);
        end
`endif
        run_op(1'b0, 1'b0, 64'h1234, 64'd0, q, r, lat, rok);
        n_cmp++;
        if ({q, r} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'h1234}) begin
            n_bad++;
            $display("FAIL udiv_zero got q=%h r=%h exp ffffffffffffffff/1234", q, r);
        end
        run_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, q, r, lat, rok);
        n_cmp++;
        if ({q, r} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB}) begin
            n_bad++;
            $display("FAIL sdiv_zero got q=%h r=%h exp ffffffffffffffff/fffffffffffffffb", q, r);
        end
        n_cmp++;
`ifdef YSYX_22050518_DIV_FAST_EN
        if (lat !== 1) begin
`else
        if (lat !== 65) begin
`endif
            n_bad++;
            $display("FAIL sdiv_zero_lat got %0d", lat);
        end
    endtask

    task automatic test_random;
        logic [63:0] a, b, q, r, eq, er;
        bit w, s, rok;
        int lat, el;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom);
            s = 1'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = w ? {b[63:32], 32'd0} : 64'd0;
                1: begin
                    s = 1'b1;
                    a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = w ? {b[63:32], 32'hFFFF_FFFF} : '1;
                end
                2: begin
                    a = 64'($urandom_range(0, 1000));
                    b = 64'($urandom_range(1, 40));
                end
                3: b = {32'd0, 16'd0, b[15:0]};
                default: ;
            endcase
            ref_div(w, s, a, b, eq, er);
            el = ref_lat(w, s, a, b);
            run_op(w, s, a, b, q, r, lat, rok);
            n_cmp++;
            if ({q, r} !== {eq, er} || lat != el || (el > 1 && !rok)) begin
                n_bad++;
                $display("FAIL rand%0d w=%0d s=%0d a=%h b=%h got q=%h r=%h lat=%0d rok=%0d exp q=%h r=%h lat=%0d",
                         i, w, s, a, b, q, r, lat, rok, eq, er, el);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] q, r, eq, er;
        int lat;
        bit rok;
        run_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, q, r, lat, rok);
        n_cmp++;
        if (io.div_ready !== 1'b1 || io.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_done got rdy=%b ov=%b exp 1/1", io.div_ready, io.out_valid);
        end
        ref_div(1'b1, 1'b0, 64'hDEAD_0000_0001_0000, 64'h0000_0000_0000_0003, eq, er);
        run_op(1'b1, 1'b0, 64'hDEAD_0000_0001_0000, 64'h0000_0000_0000_0003,
               q, r, lat, rok);
        n_cmp++;
        if ({q, r} !== {eq, er} || lat != 33 || !rok) begin
            n_bad++;
            $display("FAIL b2b_second got q=%h r=%h lat=%0d rok=%0d exp q=%h r=%h lat=33",
                     q, r, lat, rok, eq, er);
        end
    endtask

    task automatic test_flush;
        logic [63:0] q, r;
        int lat;
        bit rok, seen;
        run_op(1'b0, 1'b0, 64'd100, 64'd7, q, r, lat, rok);
        io.divw = 1'b0;
        io.div_signed = 1'b0;
        io.dividend = 64'hFFFF_0000_1234_5678;
        io.divisor = 64'd3;
        io.div_valid = 1'b1;
        @(posedge clk);
        #1;
        io.div_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        io.flush = 1'b1;
        @(posedge clk);
        #1;
        io.flush = 1'b0;
        n_cmp++;
        if (io.out_valid !== 1'b0 || io.div_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_calc got ov=%b rdy=%b exp 0/1", io.out_valid, io.div_ready);
        end
        n_cmp++;
        if (io.quotient !== 64'd14 || io.remainder !== 64'd2) begin
            n_bad++;
            $display("FAIL flush_hold got q=%h r=%h exp 14/2", io.quotient, io.remainder);
        end
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (io.out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL flush_noresult got out_valid=1 exp 0");
        end
        run_op(1'b0, 1'b0, 64'd9, 64'd3, q, r, lat, rok);
        n_cmp++;
        if ({q, r} !== {64'd3, 64'd0} || lat != 65) begin
            n_bad++;
            $display("FAIL after_flush_9_3 got q=%h r=%h lat=%0d exp 3/0/65", q, r, lat);
        end
        // flush with a DONE-cycle request: request dropped
        run_op(1'b0, 1'b0, 64'd20, 64'd6, q, r, lat, rok);
        io.dividend = 64'd50;
        io.divisor = 64'd5;
        io.div_valid = 1'b1;
        io.flush = 1'b1;
        @(posedge clk);
        #1;
        io.div_valid = 1'b0;
        io.flush = 1'b0;
        n_cmp++;
        if (io.out_valid !== 1'b0 || io.div_ready !== 1'b1 ||
            io.quotient !== 64'd3 || io.remainder !== 64'd2) begin
            n_bad++;
            $display("FAIL flush_done got ov=%b rdy=%b q=%h r=%h exp 0/1/3/2",
                     io.out_valid, io.div_ready, io.quotient, io.remainder);
        end
        // flush with a request in IDLE
        io.div_valid = 1'b1;
        io.flush = 1'b1;
        @(posedge clk);
        #1;
        io.div_valid = 1'b0;
        io.flush = 1'b0;
        seen = 1'b0;
        repeat (70) begin
            if (io.div_ready !== 1'b1 || io.out_valid === 1'b1) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL flush_idle_req got accepted exp dropped");
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] q, r;
        int lat;
        bit rok, seen;
        io.divw = 1'b0;
        io.div_signed = 1'b1;
        io.dividend = 64'h7000_0000_0000_0001;
        io.divisor = 64'd5;
        io.div_valid = 1'b1;
        @(posedge clk);
        #1;
        io.div_valid = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (io.div_ready !== 1'b1 || io.out_valid !== 1'b0 ||
            io.quotient !== 64'd0 || io.remainder !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_mid got rdy=%b ov=%b q=%h r=%h exp 1/0/0/0",
                     io.div_ready, io.out_valid, io.quotient, io.remainder);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (io.out_valid === 1'b1 || io.div_ready !== 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL reset_release got stray out_valid or busy exp idle");
        end
        run_op(1'b1, 1'b0, 64'hFFFF_FFFF_0000_0064, 64'd7, q, r, lat, rok);
        n_cmp++;
        if ({q, r} !== {64'd14, 64'd2} || lat != 33) begin
            n_bad++;
            $display("FAIL post_reset_divuw got q=%h r=%h lat=%0d exp 14/2/33", q, r, lat);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
